branch_predict_unit: RTL and testbench
======================================

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC width.
REQ-002 SHALL have parameter BHT_DEPTH, default 64: number of counters; power of 2, 4..1024.
REQ-003 SHALL have parameter CTR_BITS, default 2: saturating counter width, 2..4.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port lu_pc, input, XLEN: fetch-stage PC for prediction lookup.
REQ-007 SHALL have port pred_taken, output, 1: combinational prediction for lu_pc.
REQ-008 SHALL have port rs_valid, input, 1: resolve-stage instruction valid.
REQ-009 SHALL have port rs_branch, input, 1: resolve-stage instruction is a conditional branch.
REQ-010 SHALL have port rs_pc, input, XLEN: PC of the resolving branch.
REQ-011 SHALL have port rs_funct3, input, 3: branch condition code.
REQ-012 SHALL have ports rs_zf, rs_cf, rs_sf, rs_vf, input, 1 each: ALU zero, carry, sign and overflow flags.
REQ-013 SHALL have port rs_pred, input, 1: prediction that was made for this branch at fetch.
REQ-014 SHALL have port rs_taken, output, 1: combinational resolved outcome.
REQ-015 SHALL have port mispredict, output, 1: registered flush request.
REQ-016 SHALL have port bad_funct3, output, 1: registered illegal-condition flag.
REQ-017 SHALL have ports br_cnt and mp_cnt, output, 32 each: statistics counters (see Configuration).

Function
REQ-018 SHALL compute cond = BEQ(000): zf; BNE(001): !zf; BLT(100): sf!=vf; BGE(101): sf==vf; BLTU(110): !cf; BGEU(111): cf; 010 and 011: 0.
REQ-019 SHALL drive rs_taken = cond & rs_valid & rs_branch.
REQ-020 SHALL index the table with pc[log2(BHT_DEPTH)+1:2], ignoring pc[1:0].
REQ-021 SHALL drive pred_taken = MSB of the counter at the lu_pc index, read with zero latency.
REQ-022 On each edge with rs_valid & rs_branch, SHALL increment the counter at the rs_pc index if rs_taken, or decrement it otherwise, saturating at 2^CTR_BITS-1 and 0.
REQ-023 When lookup and update hit the same index in one cycle, SHALL return the pre-update value on pred_taken; the new value is visible next cycle.
REQ-024 SHALL register mispredict = rs_valid & rs_branch & (rs_taken != rs_pred); the pulse appears one cycle after resolve and lasts one cycle unless the next resolve also mispredicts.
REQ-025 SHALL register bad_funct3 = rs_valid & rs_branch & (rs_funct3 is 010 or 011); illegal codes SHALL still update the counter as not-taken.
REQ-026 SHALL NOT change any state when rs_valid=0 or rs_branch=0.

Reset
REQ-027 When rst is asserted, SHALL immediately (asynchronously) set every counter to weakly-not-taken, 2^(CTR_BITS-1)-1.
REQ-028 When rst is asserted, SHALL immediately clear mispredict, bad_funct3, br_cnt and mp_cnt to 0.
REQ-029 SHALL discard any update that coincides with rst, including an rst assertion mid-cycle.
REQ-030 From the first edge after rst deasserts, SHALL operate normally; with no update yet, pred_taken SHALL be 0.

Configuration
REQ-031 Macro BPU_STATS_EN: when defined, br_cnt SHALL count resolved branches (rs_valid & rs_branch).
REQ-032 With BPU_STATS_EN defined, mp_cnt SHALL count mispredicts.
REQ-033 With BPU_STATS_EN defined, both counters SHALL update on the same edge as the table and saturate at 0xFFFFFFFF.
REQ-034 With BPU_STATS_EN undefined, br_cnt and mp_cnt SHALL be constant 0 and no counter flops SHALL be synthesised.

Verification
REQ-035 Check reset values: after rst, any lu_pc -> pred_taken=0, mispredict=0; with default parameters, the counter at index 5 reads 01.
REQ-036 Check training and mispredict: rs_pc=0x100, BEQ with zf=1, rs_pred=0, resolved on 2 consecutive cycles -> rs_taken=1 both cycles, mispredict=1 on the cycle after each; then lu_pc=0x100 -> pred_taken=1 (counter 11).
REQ-037 Check saturation: 5 taken updates on index 3, then 1 not-taken -> counter=10, pred_taken=1; starting from 00, one not-taken update -> counter stays 00.
REQ-038 Check the condition table: sweep all funct3 with flag combinations zf/cf/sf/vf -> rs_taken matches REQ-018; funct3=010 -> bad_funct3=1 next cycle.
REQ-039 Check aliasing and same-cycle read/write: lu_pc=0x104, rs_pc=0x204 taken in the same cycle (default depth, both index 1) -> pred_taken shows the old value that cycle and the new value the next cycle.
REQ-040 Check statistics: with BPU_STATS_EN, 10 branches with 3 mispredicts -> br_cnt=10, mp_cnt=3; rst mid-run -> both 0 immediately; without the macro -> both always 0.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: direct-mapped saturating counters, branch-condition resolve and mispredict flag.
// Optional statistics counters are enabled by defining BPU_STATS_EN.
module branch_predict_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned CTR_BITS  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lu_pc,
  output logic            pred_taken,
  input  logic            rs_valid,
  input  logic            rs_branch,
  input  logic [XLEN-1:0] rs_pc,
  input  logic [2:0]      rs_funct3,
  input  logic            rs_zf,
  input  logic            rs_cf,
  input  logic            rs_sf,
  input  logic            rs_vf,
  input  logic            rs_pred,
  output logic            rs_taken,
  output logic            mispredict,
  output logic            bad_funct3,
  output logic [31:0]     br_cnt,
  output logic [31:0]     mp_cnt
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
  localparam logic [CTR_BITS-1:0] CTR_WNT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  logic [CTR_BITS-1:0] bht_q [BHT_DEPTH];
  logic [IDX_W-1:0]    lu_idx;
  logic [IDX_W-1:0]    rs_idx;
  logic [CTR_BITS-1:0] rs_ctr;
  logic [CTR_BITS-1:0] ctr_d;
  logic                cond;
  logic                upd;
  logic                illegal;
  logic                mispredict_q;
  logic                bad_funct3_q;
  logic                unused_pc_bits;

  assign lu_idx  = lu_pc[IDX_W+1:2];
  assign rs_idx  = rs_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{lu_pc, rs_pc};

  // Read is purely combinational, so a same-cycle write to this entry shows up next cycle.
  assign pred_taken = bht_q[lu_idx][CTR_BITS-1];
  assign rs_ctr     = bht_q[rs_idx];

  always_comb begin
    cond = 1'b0;
    case (rs_funct3)
      3'b000:  cond = rs_zf;
      3'b001:  cond = ~rs_zf;
      3'b100:  cond = rs_sf ^ rs_vf;
      3'b101:  cond = ~(rs_sf ^ rs_vf);
      3'b110:  cond = ~rs_cf;
      3'b111:  cond = rs_cf;
      default: cond = 1'b0;
    endcase
  end

  assign upd      = rs_valid & rs_branch;
  assign rs_taken = cond & upd;
  assign illegal  = (rs_funct3 == 3'b010) | (rs_funct3 == 3'b011);

  always_comb begin
    ctr_d = rs_ctr;
    if (rs_taken) begin
      if (rs_ctr != CTR_MAX) ctr_d = rs_ctr + CTR_BITS'(1);
    end else if (rs_ctr != '0) begin
      ctr_d = rs_ctr - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CTR_WNT;
    end else if (upd) begin
      bht_q[rs_idx] <= ctr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict_q <= 1'b0;
      bad_funct3_q <= 1'b0;
    end else begin
      mispredict_q <= upd & (rs_taken != rs_pred);
      bad_funct3_q <= upd & illegal;
    end
  end

  assign mispredict = mispredict_q;
  assign bad_funct3 = bad_funct3_q;

`ifdef BPU_STATS_EN
  logic [31:0] br_cnt_q;
  logic [31:0] mp_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else if (upd) begin
      if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + 32'd1;
      if ((rs_taken != rs_pred) && (mp_cnt_q != '1)) mp_cnt_q <= mp_cnt_q + 32'd1;
    end
  end

  assign br_cnt = br_cnt_q;
  assign mp_cnt = mp_cnt_q;
`else
  assign br_cnt = '0;
  assign mp_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit against an array-of-integers predictor model.
module tb_branch_predict_unit;
  localparam int DEPTH = 64;
  localparam int CB    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lu_pc;
  logic        pred_taken;
  logic        rs_valid, rs_branch;
  logic [31:0] rs_pc;
  logic [2:0]  rs_funct3;
  logic        rs_zf, rs_cf, rs_sf, rs_vf, rs_pred;
  logic        rs_taken, mispredict, bad_funct3;
  logic [31:0] br_cnt, mp_cnt;

  int checks = 0;
  int errors = 0;
  int ctr [DEPTH];
  int br_m, mp_m;

  branch_predict_unit #(.XLEN(32), .BHT_DEPTH(DEPTH), .CTR_BITS(CB)) dut (
    .clk(clk), .rst(rst), .lu_pc(lu_pc), .pred_taken(pred_taken),
    .rs_valid(rs_valid), .rs_branch(rs_branch), .rs_pc(rs_pc), .rs_funct3(rs_funct3),
    .rs_zf(rs_zf), .rs_cf(rs_cf), .rs_sf(rs_sf), .rs_vf(rs_vf), .rs_pred(rs_pred),
    .rs_taken(rs_taken), .mispredict(mispredict), .bad_funct3(bad_funct3),
    .br_cnt(br_cnt), .mp_cnt(mp_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic bit ref_cond(input logic [2:0] f3, input logic [3:0] fl);
    logic zf, cf, sf, vf;
    {zf, cf, sf, vf} = fl;
    case (f3)
      3'd0: return zf;
      3'd1: return !zf;
      3'd4: return sf != vf;
      3'd5: return sf == vf;
      3'd6: return !cf;
      3'd7: return cf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int ref_idx(input logic [31:0] pc);
    return int'((pc / 4) % DEPTH);
  endfunction

  function automatic bit ref_pred(input logic [31:0] pc);
    return ctr[ref_idx(pc)] >= (1 << (CB - 1));
  endfunction

  function automatic logic [31:0] exp_br();
`ifdef BPU_STATS_EN
    return 32'(br_m);
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_mp();
`ifdef BPU_STATS_EN
    return 32'(mp_m);
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ctr[i] = (1 << (CB - 1)) - 1;
    br_m = 0;
    mp_m = 0;
  endtask

  task automatic model_step(input bit upd, input logic [31:0] pc, input bit taken,
                            input bit pred, output bit e_mp);
    int i;
    e_mp = 1'b0;
    if (upd) begin
      i = ref_idx(pc);
      if (taken) ctr[i] = (ctr[i] + 1 > (1 << CB) - 1) ? (1 << CB) - 1 : ctr[i] + 1;
      else       ctr[i] = (ctr[i] - 1 < 0) ? 0 : ctr[i] - 1;
      br_m++;
      if (taken != pred) begin
        mp_m++;
        e_mp = 1'b1;
      end
    end
  endtask

  task automatic apply(input bit v, input bit b, input logic [31:0] pc, input logic [2:0] f3,
                       input logic [3:0] fl, input bit pred, input logic [31:0] lpc);
    rs_valid  = v;
    rs_branch = b;
    rs_pc     = pc;
    rs_funct3 = f3;
    {rs_zf, rs_cf, rs_sf, rs_vf} = fl;
    rs_pred   = pred;
    lu_pc     = lpc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply(0, 0, 32'h0, 3'd0, 4'h0, 0, 32'h0);
    #3;
    for (int k = 0; k < 4; k++) begin
      lu_pc = $urandom;
      #1;
      checks++;
      if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred: got %b expected 0 (pc %h)", pred_taken, lu_pc); end
    end
    checks++;
    if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict: got %b expected 0", mispredict); end
    checks++;
    if (bad_funct3 !== 1'b0) begin errors++; $display("FAIL reset_bad_funct3: got %b expected 0", bad_funct3); end
    checks++;
    if (br_cnt !== 32'd0 || mp_cnt !== 32'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", br_cnt, mp_cnt); end
    checks++;
    if (dut.bht_q[5] !== 2'b01) begin errors++; $display("FAIL reset_ctr5: got %b expected 01", dut.bht_q[5]); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    lu_pc = 32'h14;
    @(negedge clk);
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL post_reset_pred: got %b expected 0", pred_taken); end
    @(posedge clk); #1;
  endtask

  task automatic test_training();
    bit em;
    for (int k = 0; k < 2; k++) begin
      apply(1, 1, 32'h100, 3'b000, 4'b1000, 0, 32'h100);
      @(negedge clk);
      checks++;
      if (rs_taken !== 1'b1) begin errors++; $display("FAIL train_taken: got %b expected 1", rs_taken); end
      checks++;
      if (pred_taken !== ref_pred(32'h100)) begin errors++; $display("FAIL train_pred: got %b expected %b", pred_taken, ref_pred(32'h100)); end
      @(posedge clk);
      model_step(1, 32'h100, 1, 0, em);
      #1;
      checks++;
      if (mispredict !== 1'b1) begin errors++; $display("FAIL train_mispredict: got %b expected 1", mispredict); end
    end
    apply(0, 0, 32'h0, 3'd0, 4'h0, 0, 32'h100);
    @(negedge clk);
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("FAIL train_pred_after: got %b expected 1", pred_taken); end
    checks++;
    if (dut.bht_q[0] !== 2'b11) begin errors++; $display("FAIL train_ctr: got %b expected 11", dut.bht_q[0]); end
    @(posedge clk); #1;
    checks++;
    if (mispredict !== 1'b0) begin errors++; $display("FAIL train_mp_drop: got %b expected 0", mispredict); end
  endtask

  task automatic test_saturation();
    bit em, tk;
    for (int k = 0; k < 6; k++) begin
      tk = (k < 5);
      apply(1, 1, 32'hC, tk ? 3'b000 : 3'b001, 4'b1000, 1, 32'hC);
      @(negedge clk);
      checks++;
      if (rs_taken !== tk) begin errors++; $display("FAIL sat_taken: got %b expected %b", rs_taken, tk); end
      checks++;
      if (pred_taken !== ref_pred(32'hC)) begin errors++; $display("FAIL sat_pred: got %b expected %b", pred_taken, ref_pred(32'hC)); end
      @(posedge clk);
      model_step(1, 32'hC, tk, 1, em);
      #1;
      checks++;
      if (mispredict !== em) begin errors++; $display("FAIL sat_mispredict: got %b expected %b", mispredict, em); end
    end
    apply(0, 0, 32'h0, 3'd0, 4'h0, 0, 32'hC);
    #1;
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_hi_pred: got %b expected 1", pred_taken); end
    checks++;
    if (dut.bht_q[3] !== 2'b10) begin errors++; $display("FAIL sat_hi_ctr: got %b expected 10", dut.bht_q[3]); end
    for (int k = 0; k < 3; k++) begin
      apply(1, 1, 32'h24, 3'b001, 4'b1000, 0, 32'h24);
      @(negedge clk);
      checks++;
      if (pred_taken !== ref_pred(32'h24)) begin errors++; $display("FAIL sat_lo_pred: got %b expected %b", pred_taken, ref_pred(32'h24)); end
      @(posedge clk);
      model_step(1, 32'h24, 0, 0, em);
      #1;
    end
    apply(0, 0, 32'h0, 3'd0, 4'h0, 0, 32'h24);
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_lo_pred_after: got %b expected 0", pred_taken); end
    checks++;
    if (dut.bht_q[9] !== 2'b00) begin errors++; $display("FAIL sat_lo_ctr: got %b expected 00", dut.bht_q[9]); end
    @(posedge clk); #1;
  endtask

  task automatic test_cond_table();
    bit em, exp_t, exp_bad;
    logic [31:0] pc;
    bit pr;
    for (int f = 0; f < 8; f++) begin
      for (int fl = 0; fl < 16; fl++) begin
        pc = ($urandom_range(0, 7) << 2) + 32'h800;
        pr = 1'($urandom_range(0, 1));
        apply(1, 1, pc, 3'(f), 4'(fl), pr, pc);
        exp_t = ref_cond(3'(f), 4'(fl));
        exp_bad = (f == 2) || (f == 3);
        @(negedge clk);
        checks++;
        if (rs_taken !== exp_t) begin errors++; $display("FAIL cond_taken f3=%0d fl=%h: got %b expected %b", f, fl, rs_taken, exp_t); end
        checks++;
        if (pred_taken !== ref_pred(pc)) begin errors++; $display("FAIL cond_pred: got %b expected %b", pred_taken, ref_pred(pc)); end
        @(posedge clk);
        model_step(1, pc, exp_t, pr, em);
        #1;
        checks++;
        if (mispredict !== em) begin errors++; $display("FAIL cond_mispredict: got %b expected %b", mispredict, em); end
        checks++;
        if (bad_funct3 !== exp_bad) begin errors++; $display("FAIL cond_bad_funct3 f3=%0d: got %b expected %b", f, bad_funct3, exp_bad); end
      end
    end
  endtask

  task automatic test_alias();
    bit em;
    for (int k = 0; k < 3; k++) begin
      apply(1, 1, 32'h104, (k < 2) ? 3'b001 : 3'b000, 4'b1000, 0, 32'h0);
      @(posedge clk);
      model_step(1, 32'h104, k == 2, 0, em);
      #1;
    end
    apply(1, 1, 32'h204, 3'b000, 4'b1000, 1, 32'h104);
    @(negedge clk);
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_old: got %b expected 0", pred_taken); end
    @(posedge clk);
    model_step(1, 32'h204, 1, 1, em);
    #1;
    apply(0, 0, 32'h0, 3'd0, 4'h0, 0, 32'h104);
    #1;
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("FAIL alias_new: got %b expected 1", pred_taken); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit em, v, b, pr, exp_t, exp_bad;
    logic [31:0] pc, lpc;
    logic [2:0] f3;
    logic [3:0] fl;
    for (int k = 0; k < 400; k++) begin
      v   = ($urandom_range(0, 3) != 0);
      b   = ($urandom_range(0, 3) != 0);
      pc  = ($urandom & 32'hFFFF0000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      lpc = ($urandom & 32'hFFFF0000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      f3  = 3'($urandom);
      fl  = 4'($urandom);
      pr  = 1'($urandom_range(0, 1));
      apply(v, b, pc, f3, fl, pr, lpc);
      exp_t   = v && b && ref_cond(f3, fl);
      exp_bad = v && b && (f3 == 3'd2 || f3 == 3'd3);
      @(negedge clk);
      checks++;
      if (rs_taken !== exp_t) begin errors++; $display("FAIL rnd_taken: got %b expected %b", rs_taken, exp_t); end
      checks++;
      if (pred_taken !== ref_pred(lpc)) begin errors++; $display("FAIL rnd_pred pc=%h: got %b expected %b", lpc, pred_taken, ref_pred(lpc)); end
      checks++;
      if (br_cnt !== exp_br() || mp_cnt !== exp_mp()) begin errors++; $display("FAIL rnd_stats: got %0d/%0d expected %0d/%0d", br_cnt, mp_cnt, exp_br(), exp_mp()); end
      @(posedge clk);
      model_step(v && b, pc, exp_t, pr, em);
      #1;
      checks++;
      if (mispredict !== em) begin errors++; $display("FAIL rnd_mispredict: got %b expected %b", mispredict, em); end
      checks++;
      if (bad_funct3 !== exp_bad) begin errors++; $display("FAIL rnd_bad_funct3: got %b expected %b", bad_funct3, exp_bad); end
    end
  endtask

  task automatic test_stats();
    bit em;
    rst = 1'b1;
    apply(0, 0, 32'h0, 3'd0, 4'h0, 0, 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      apply(1, 1, 32'h40 + 32'(k * 4), 3'b000, 4'b1000, k >= 3, 32'h0);
      @(posedge clk);
      model_step(1, 32'h40 + 32'(k * 4), 1, k >= 3, em);
      #1;
    end
    checks++;
    if (br_cnt !== exp_br()) begin errors++; $display("FAIL stats_br: got %0d expected %0d", br_cnt, exp_br()); end
    checks++;
    if (mp_cnt !== exp_mp()) begin errors++; $display("FAIL stats_mp: got %0d expected %0d", mp_cnt, exp_mp()); end
    apply(1, 1, 32'h1C0, 3'b000, 4'b1000, 0, 32'h1C0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (br_cnt !== 32'd0 || mp_cnt !== 32'd0) begin errors++; $display("FAIL stats_async_clr: got %0d/%0d expected 0/0", br_cnt, mp_cnt); end
    checks++;
    if (mispredict !== 1'b0) begin errors++; $display("FAIL async_mispredict: got %b expected 0", mispredict); end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    apply(0, 0, 32'h0, 3'd0, 4'h0, 0, 32'h1C0);
    @(negedge clk);
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_discard_pred: got %b expected 0", pred_taken); end
    checks++;
    if (br_cnt !== 32'd0 || mp_cnt !== 32'd0) begin errors++; $display("FAIL rst_discard_stats: got %0d/%0d expected 0/0", br_cnt, mp_cnt); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_training();
    test_saturation();
    test_cond_table();
    test_alias();
    test_random();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
